// File: rtl/long_latency_scoreboard.sv
// ----------------------------------------------------------------------------
// long_latency_scoreboard
//
// Purpose:
//   Tracks the destination registers of long-latency writes (loads, mul/div)
//   from the cycle they issue out of ID until they retire in WB. The ID stage
//   is stalled while the current instruction reads or overwrites a register
//   whose result has not been produced yet. Single-cycle ALU results never
//   enter this block; the EX/MEM forwarding path covers them.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   ID_*_i              decoded operands/destination of the instruction in ID
//   ID_flush_i          ID instruction squashed this cycle (suppresses issue)
//   WB_*_i              register-file write port in WB
//   stall_o             hold PC and IF/ID, bubble into EX
//   pending_o           pending bitmap, bit 0 always 0
//   count_o             number of set pending bits
//   err_o               sticky: a long-latency retire hit a non-pending reg
// ----------------------------------------------------------------------------
module long_latency_scoreboard #(
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_valid_i,
    input  logic [4:0]       ID_rs1_addr_i,
    input  logic             ID_rs1_used_i,
    input  logic [4:0]       ID_rs2_addr_i,
    input  logic             ID_rs2_used_i,
    input  logic [4:0]       ID_rd_addr_i,
    input  logic             ID_RegWrite_i,
    input  logic             ID_long_lat_i,
    input  logic             ID_flush_i,
    input  logic             WB_RegWrite_i,
    input  logic [4:0]       WB_rd_addr_i,
    input  logic             WB_long_lat_i,
    output logic             stall_o,
    output logic [31:0]      pending_o,
    output logic [CNT_W-1:0] count_o,
    output logic             err_o
);

    logic [31:0]      r_pending;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    logic             w_id_live;
    logic             w_raw1;
    logic             w_raw2;
    logic             w_waw;
    logic             w_full;
    logic             w_stall;
    logic             w_set;
    logic             w_clr_req;
    logic             w_clr_hit;
    logic [31:0]      w_set_mask;
    logic [31:0]      w_clr_mask;

    assign w_id_live = ID_valid_i & ~ID_flush_i;

    // x0 is never pending (bit 0 held at 0), so x0 reads/writes cannot stall.
    assign w_raw1 = ID_rs1_used_i & r_pending[ID_rs1_addr_i];
    assign w_raw2 = ID_rs2_used_i & r_pending[ID_rs2_addr_i];
    assign w_waw  = ID_RegWrite_i & r_pending[ID_rd_addr_i];

    // Capacity only blocks an instruction that would actually take a slot.
    assign w_full = ID_RegWrite_i & ID_long_lat_i & (ID_rd_addr_i != 5'd0) &
                    (r_count == CNT_W'(MAX_PENDING));

    // Stall uses the pre-edge bitmap: a retire in WB releases the stall one
    // cycle later, and a same-register set/clear pair is impossible because
    // the WAW term already blocks the issue.
    assign w_stall = w_id_live & (w_raw1 | w_raw2 | w_waw | w_full);
    assign stall_o = w_stall;

    assign w_set = w_id_live & ~w_stall & ID_RegWrite_i & ID_long_lat_i &
                   (ID_rd_addr_i != 5'd0);

    assign w_clr_req = WB_RegWrite_i & WB_long_lat_i & (WB_rd_addr_i != 5'd0);
    assign w_clr_hit = w_clr_req & r_pending[WB_rd_addr_i];

    assign w_set_mask = w_set     ? (32'd1 << ID_rd_addr_i) : 32'd0;
    assign w_clr_mask = w_clr_hit ? (32'd1 << WB_rd_addr_i) : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 32'd0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_pending <= ((r_pending & ~w_clr_mask) | w_set_mask) & 32'hFFFF_FFFE;
            // Set and clear on different registers cancel out in the count.
            case ({w_set, w_clr_hit})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // Retiring something never issued means the pipeline lost track.
            if (w_clr_req & ~w_clr_hit)
                r_err <= 1'b1;
        end
    end

    assign pending_o = r_pending;
    assign count_o   = r_count;
    assign err_o     = r_err;

endmodule

// File: tb/tb_long_latency_scoreboard.sv
module tb_long_latency_scoreboard;

    localparam int MAXP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, rs1u, rs2u, rw, ll, flush;
    logic [4:0]  rs1, rs2, rd;
    logic        wbrw, wbll;
    logic [4:0]  wbrd;
    logic        stall;
    logic [31:0] pending;
    logic [4:0]  count;
    logic        err;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: the set of outstanding destination registers.
    int pend_q[$];
    bit m_err;

    always #5 clk = ~clk;

    long_latency_scoreboard #(.MAX_PENDING(MAXP), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .ID_valid_i(id_valid), .ID_rs1_addr_i(rs1), .ID_rs1_used_i(rs1u),
        .ID_rs2_addr_i(rs2), .ID_rs2_used_i(rs2u), .ID_rd_addr_i(rd),
        .ID_RegWrite_i(rw), .ID_long_lat_i(ll), .ID_flush_i(flush),
        .WB_RegWrite_i(wbrw), .WB_rd_addr_i(wbrd), .WB_long_lat_i(wbll),
        .stall_o(stall), .pending_o(pending), .count_o(count), .err_o(err)
    );

    function automatic int m_find(input int r);
        for (int i = 0; i < pend_q.size(); i++)
            if (pend_q[i] == r) return i;
        return -1;
    endfunction

    function automatic bit m_stall();
        if (!id_valid || flush) return 1'b0;
        if (rs1u && m_find(int'(rs1)) >= 0) return 1'b1;
        if (rs2u && m_find(int'(rs2)) >= 0) return 1'b1;
        if (rw && m_find(int'(rd)) >= 0) return 1'b1;
        if (rw && ll && rd != 0 && pend_q.size() == MAXP) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_map();
        logic [31:0] m = 32'd0;
        foreach (pend_q[i]) m[pend_q[i]] = 1'b1;
        return m;
    endfunction

    function automatic logic [4:0] m_cnt();
        return 5'(pend_q.size());
    endfunction

    task automatic idle();
        id_valid = 0; rs1 = 0; rs1u = 0; rs2 = 0; rs2u = 0; rd = 0;
        rw = 0; ll = 0; flush = 0; wbrw = 0; wbrd = 0; wbll = 0;
    endtask

    task automatic id_long(input logic [4:0] r);
        id_valid = 1; rd = r; rw = 1; ll = 1; rs1u = 0; rs2u = 0; flush = 0;
    endtask

    task automatic wb_ret(input logic [4:0] r);
        wbrw = 1; wbll = 1; wbrd = r;
    endtask

    // One clock edge with the model advanced from the pre-edge inputs.
    task automatic tick();
        bit iss;
        int idx;
        iss = id_valid && !flush && !m_stall() && rw && ll && rd != 0;
        @(posedge clk);
        if (rst) begin
            pend_q.delete();
            m_err = 0;
        end else begin
            if (wbrw && wbll && wbrd != 0) begin
                idx = m_find(int'(wbrd));
                if (idx >= 0) pend_q.delete(idx);
                else m_err = 1;
            end
            if (iss) pend_q.push_back(int'(rd));
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            id_valid = 1'($urandom); rs1 = 5'($urandom); rs1u = 1'($urandom);
            rs2 = 5'($urandom); rs2u = 1'($urandom); rd = 5'($urandom);
            rw = 1'($urandom); ll = 1'($urandom); flush = 1'($urandom);
            wbrw = 1'($urandom); wbrd = 5'($urandom); wbll = 1'($urandom);
            tick();
        end
        rst = 0;
        idle();
        total_cnt++;
        if (pending !== 32'd0) $display("FAIL reset_pending: got %h want 0", pending); else pass_cnt++;
        total_cnt++;
        if (count !== 5'd0) $display("FAIL reset_count: got %0d want 0", count); else pass_cnt++;
        total_cnt++;
        if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else pass_cnt++;
        id_valid = 1; rs1 = 5; rs1u = 1; #1;
        total_cnt++;
        if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else pass_cnt++;
        idle();
    endtask

    task automatic test_load_use();
        idle(); id_long(5); tick();
        idle(); id_valid = 1; rs1 = 5; rs1u = 1; #1;
        total_cnt++;
        if (stall !== 1'b1) $display("FAIL lu_stall_c1: got %b want 1", stall); else pass_cnt++;
        tick(); tick();
        wb_ret(5); #1;
        total_cnt++;
        if (stall !== 1'b1) $display("FAIL lu_stall_c3: got %b want 1", stall); else pass_cnt++;
        tick();
        wbrw = 0; wbll = 0; wbrd = 0; #1;
        total_cnt++;
        if (stall !== 1'b0) $display("FAIL lu_stall_c4: got %b want 0", stall); else pass_cnt++;
        total_cnt++;
        if (pending[5] !== 1'b0 || count !== 5'd0)
            $display("FAIL lu_state: got pend5=%b cnt=%0d want 0/0", pending[5], count);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_x0_unused();
        idle(); id_long(0); tick();
        total_cnt++;
        if (pending !== 32'd0) $display("FAIL x0_write: got %h want 0", pending); else pass_cnt++;
        id_long(7); tick();
        idle(); id_valid = 1; rs2 = 7; rs2u = 0; rs1 = 0; rs1u = 1; #1;
        total_cnt++;
        if (stall !== 1'b0) $display("FAIL unused_rs2: got %b want 0", stall); else pass_cnt++;
        rs2u = 1; #1;
        total_cnt++;
        if (stall !== 1'b1) $display("FAIL used_rs2: got %b want 1", stall); else pass_cnt++;
        idle(); wb_ret(7); tick(); idle();
    endtask

    task automatic test_capacity();
        for (int r = 1; r <= 4; r++) begin
            idle(); id_long(5'(r)); tick();
        end
        total_cnt++;
        if (count !== 5'd4) $display("FAIL cap_count: got %0d want 4", count); else pass_cnt++;
        idle(); id_long(6); #1;
        total_cnt++;
        if (stall !== 1'b1) $display("FAIL cap_stall: got %b want 1", stall); else pass_cnt++;
        tick();
        total_cnt++;
        if (pending !== 32'h0000_001E || count !== 5'd4)
            $display("FAIL cap_nochange: got %h/%0d want 0000001e/4", pending, count);
        else pass_cnt++;
        wb_ret(2); #1;
        total_cnt++;
        if (stall !== 1'b1) $display("FAIL cap_ret_same_cycle: got %b want 1", stall); else pass_cnt++;
        tick();
        wbrw = 0; wbll = 0; wbrd = 0; #1;
        total_cnt++;
        if (stall !== 1'b0) $display("FAIL cap_release: got %b want 0", stall); else pass_cnt++;
        tick();
        total_cnt++;
        if (pending !== 32'h0000_005A || count !== 5'd4)
            $display("FAIL cap_issue6: got %h/%0d want 0000005a/4", pending, count);
        else pass_cnt++;
        idle();
        foreach (pend_q[i]) ;
        while (pend_q.size() > 0) begin
            wb_ret(5'(pend_q[0])); tick();
        end
        idle();
    endtask

    task automatic test_simul_waw();
        idle(); id_long(9); tick();
        id_long(9); wb_ret(9); #1;
        total_cnt++;
        if (stall !== 1'b1) $display("FAIL waw_stall: got %b want 1", stall); else pass_cnt++;
        tick();
        total_cnt++;
        if (pending[9] !== 1'b0) $display("FAIL waw_clear: got %b want 0", pending[9]); else pass_cnt++;
        wbrw = 0; wbll = 0; wbrd = 0; #1;
        total_cnt++;
        if (stall !== 1'b0) $display("FAIL waw_release: got %b want 0", stall); else pass_cnt++;
        tick();
        total_cnt++;
        if (pending[9] !== 1'b1 || count !== 5'd1)
            $display("FAIL waw_reissue: got %b/%0d want 1/1", pending[9], count);
        else pass_cnt++;
        idle(); id_long(4); tick();
        id_long(3); wb_ret(4); tick();
        total_cnt++;
        if (count !== 5'd2 || pending[3] !== 1'b1 || pending[4] !== 1'b0)
            $display("FAIL setclr_count: got %0d p3=%b p4=%b want 2/1/0", count, pending[3], pending[4]);
        else pass_cnt++;
        idle(); wb_ret(3); tick(); wb_ret(9); tick(); idle();
    endtask

    task automatic test_flush_err();
        logic [4:0] c0;
        idle(); id_long(10); flush = 1; #1;
        total_cnt++;
        if (stall !== 1'b0) $display("FAIL flush_stall: got %b want 0", stall); else pass_cnt++;
        tick();
        total_cnt++;
        if (pending[10] !== 1'b0) $display("FAIL flush_noset: got %b want 0", pending[10]); else pass_cnt++;
        idle(); id_long(11); tick(); idle();
        c0 = m_cnt();
        wb_ret(12); tick(); idle();
        total_cnt++;
        if (err !== 1'b1 || count !== c0)
            $display("FAIL err_set: got err=%b cnt=%0d want 1/%0d", err, count, c0);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err); else pass_cnt++;
        rst = 1; tick(); rst = 0;
        total_cnt++;
        if (err !== 1'b0 || pending !== 32'd0)
            $display("FAIL err_reset: got err=%b pend=%h want 0/0", err, pending);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            id_valid = 1'($urandom); flush = ($urandom_range(0, 7) == 0);
            rs1 = 5'($urandom_range(0, 7)); rs1u = 1'($urandom);
            rs2 = 5'($urandom_range(0, 7)); rs2u = 1'($urandom);
            rd = 5'($urandom_range(0, 7)); rw = 1'($urandom); ll = 1'($urandom);
            if (pend_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                wbrd = 5'(pend_q[$urandom_range(0, pend_q.size() - 1)]);
                wbrw = 1; wbll = 1;
            end else begin
                wbrd = 5'($urandom_range(0, 7));
                wbrw = ($urandom_range(0, 9) == 0); wbll = 1'($urandom);
            end
            #1;
            total_cnt++;
            if (stall !== m_stall()) $display("FAIL rnd_stall[%0d]: got %b want %b", n, stall, m_stall());
            else pass_cnt++;
            tick();
            total_cnt++;
            if (pending !== m_map() || count !== m_cnt() || err !== m_err)
                $display("FAIL rnd_state[%0d]: got %h/%0d/%b want %h/%0d/%b",
                         n, pending, count, err, m_map(), m_cnt(), m_err);
            else pass_cnt++;
        end
        rst = 0; idle();
    endtask

    initial begin
        idle();
        rst = 1;
        m_err = 0;
        test_reset();
        test_load_use();
        test_x0_unused();
        test_capacity();
        test_simul_waw();
        test_flush_err();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/long_latency_scoreboard.md
Name: long_latency_scoreboard

Overview:
- Tracks destination registers of in-flight long-latency writes (loads, multi-cycle ops) from issue in ID until retirement in WB.
- Stalls ID while any operand or destination of the current instruction is still pending.
- Complements the combinational EX/MEM forwarding path. Single-cycle ALU results are forwarded. Results that are not yet produced are held off by this block.
- Sits beside the ID stage and is fed by the ID decode and the WB write port.

Parameters:
MAX_PENDING, 4, maximum number of simultaneously outstanding long-latency writes (1..31)
CNT_W, 5, width of the outstanding-count output; must satisfy 2**CNT_W > MAX_PENDING

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
ID_valid_i  input  1  valid instruction present in ID
ID_rs1_addr_i  input  5  source register 1 address
ID_rs1_used_i  input  1  instruction reads rs1
ID_rs2_addr_i  input  5  source register 2 address
ID_rs2_used_i  input  1  instruction reads rs2
ID_rd_addr_i  input  5  destination register address
ID_RegWrite_i  input  1  instruction writes rd
ID_long_lat_i  input  1  instruction result is long-latency (load/mul/div)
ID_flush_i  input  1  ID instruction is being squashed this cycle
WB_RegWrite_i  input  1  WB stage writes register file this cycle
WB_rd_addr_i  input  5  WB destination address
WB_long_lat_i  input  1  WB write retires a long-latency result
stall_o  output  1  hold PC and IF/ID, bubble into EX
pending_o  output  32  pending bitmap; bit 0 is always 0
count_o  output  CNT_W  number of set pending bits
err_o  output  1  sticky protocol error

Behaviour:
- Reset (rst=1 at edge): pending_o=0, count_o=0, err_o=0. rst has priority over all other inputs in the same cycle. In-flight long ops are dropped. The pipeline is flushed alongside.
- State: 32-bit pending register (bit 0 hardwired 0), CNT_W-bit counter, err flag.
- stall_o is combinational from registered state plus current ID inputs. It is 1 when ID_valid_i=1, ID_flush_i=0, and any of the following holds:
  - ID_rs1_used_i and pending[rs1]
  - ID_rs2_used_i and pending[rs2]
  - ID_RegWrite_i and pending[rd] (WAW)
  - ID_RegWrite_i and ID_long_lat_i and rd!=0 and count==MAX_PENDING
- Reads of x0 never stall.
- Issue (set) condition: ID_valid_i & !ID_flush_i & !stall_o & ID_RegWrite_i & ID_long_lat_i & rd!=0. When true, pending[rd] is set at the next edge.
- Retire (clear) condition: WB_RegWrite_i & WB_long_lat_i & WB_rd!=0. When true, pending[WB_rd] is cleared at the next edge.
- Retire to a non-pending register: bitmap and count are unchanged, and err_o is set. err_o stays set until reset.
- Same-cycle set and clear on different registers: both apply and count is unchanged.
- Same-cycle set and clear on the same register cannot both qualify. The WAW term stalls the issue because stall uses the pre-edge bitmap. A retire does not release a stall until the following cycle (1-cycle release latency).
- count: +1 on qualifying set, -1 on valid clear, net 0 on both. Never exceeds MAX_PENDING and never underflows.
- Latency:
  - Issue at edge N means a dependent instruction in ID at N+1 sees stall_o=1.
  - Retire at edge M means stall_o drops from cycle M+1.
- A flush suppresses issue only. Already-set bits stay set and clear on retirement.
- Non-long-latency writes (ID_long_lat_i=0) never touch state; forwarding covers them.

Test Plan:
- Reset: apply rst for 2 cycles with random inputs -> pending_o=0, count_o=0, err_o=0, stall_o=0 for a dependent instruction.
- Load-use: issue long write rd=5 at cycle 0, then in cycle 1 present rs1=5 used -> stall_o=1. Drive WB retire rd=5 at cycle 3 -> stall_o=1 in cycle 3, 0 in cycle 4, pending_o[5]=0, count_o=0.
- x0 and unused operands: issue long write rd=0 -> pending_o stays 0. Present rs2=7 with rs2_used=0 while pending[7]=1 -> stall_o=0.
- Capacity (MAX_PENDING=4): issue long writes to x1..x4 -> count_o=4. A fifth long write to x6 gives stall_o=1 and no state change. Retire x2 -> next cycle stall_o=0, x6 issues, count_o=4.
- Simultaneous and WAW: pending[9]=1, ID long write rd=9 while WB retires rd=9 -> stall_o=1 that cycle, pending_o[9]=0 next, issue succeeds the following cycle. Separately, set x3 while clearing x4 in the same cycle -> count_o unchanged.
- Flush and error: a long write with ID_flush_i=1 -> no bit set. WB long retire to non-pending x12 -> err_o=1, count_o unchanged, err_o holds until rst.
